raster_reader: RTL

Frame-memory reader that drives the pixel stream into the stereo window line buffer. It scans a stored frame in raster order through a 1-cycle-latency synchronous read port and emits one pixel per cycle with a shift enable. It tracks raster coordinates on the output side and flags the cycles in which the downstream line buffer holds a complete, non-wrapping window. It sits between frame RAM and the line buffer / census stage.

---
 rtl/raster_reader_pkg.sv | 24 ++
 rtl/raster_reader_counter.sv | 45 ++++
 rtl/raster_reader.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/raster_reader_pkg.sv
// Shared types and helpers for the raster frame reader.
`timescale 1ns/1ps
package raster_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Bits needed to index 0..v-1, never less than one.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p << 1;
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/raster_reader_counter.sv
// Raster x/y position counter with synchronous clear, enable and terminal flag.
`timescale 1ns/1ps
module raster_counter
    import raster_reader_pkg::*;
#(
    parameter int unsigned X_COUNT = 320,
    parameter int unsigned Y_COUNT = 240
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        en,
    output logic [clog2(X_COUNT)-1:0]   x,
    output logic [clog2(Y_COUNT)-1:0]   y,
    output logic                        last_c
);

    localparam int unsigned XW = clog2(X_COUNT);
    localparam int unsigned YW = clog2(Y_COUNT);

    logic x_last_c;
    logic y_last_c;

    assign x_last_c = (x == XW'(X_COUNT - 1));
    assign y_last_c = (y == YW'(Y_COUNT - 1));
    assign last_c   = x_last_c && y_last_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x <= '0;
            y <= '0;
        end else if (clr) begin
            x <= '0;
            y <= '0;
        end else if (en) begin
            if (x_last_c) begin
                x <= '0;
                y <= y_last_c ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

endmodule

// File: rtl/raster_reader.sv
// Scans a stored frame in raster order through a 1-cycle synchronous read port and
// streams pixels to the window line buffer, flagging complete non-wrapping windows.
`timescale 1ns/1ps
module raster_reader
    import raster_reader_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned LINE_LENGTH = 320,
    parameter int unsigned NUM_LINES   = 240,
    parameter int unsigned WIN_W       = 5,
    parameter int unsigned WIN_H       = 5,
    parameter int unsigned ADDR_WIDTH  = 17
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            ready,
    output logic                            mem_rd,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    input  logic [WIDTH-1:0]                mem_rdata,
    output logic [WIDTH-1:0]                pix_out,
    output logic                            pix_en,
    output logic                            win_valid,
    output logic [clog2(LINE_LENGTH)-1:0]   win_x,
    output logic [clog2(NUM_LINES)-1:0]     win_y,
    output logic                            busy,
    output logic                            done
);

    localparam int unsigned XW = clog2(LINE_LENGTH);
    localparam int unsigned YW = clog2(NUM_LINES);

    generate
        if (WIN_W == 0 || WIN_H == 0 || WIN_W > LINE_LENGTH || WIN_H > NUM_LINES ||
            (64'(1) << ADDR_WIDTH) < 64'(LINE_LENGTH * NUM_LINES)) begin : g_param_err
            $error("raster_reader: illegal parameter combination");
        end
    endgenerate

    state_t          state;
    logic            rd_active;
    logic            rd_pend;
    logic            frame_start_c;
    logic            rd_last_c;
    logic            out_last_c;
    logic [XW-1:0]   ox;
    logic [YW-1:0]   oy;
    logic [XW-1:0]   rd_x_unused;
    logic [YW-1:0]   rd_y_unused;

    assign frame_start_c = (state == ST_IDLE) && start;
    // The read strobe follows ready in the same cycle so a stall costs no extra slot.
    assign mem_rd        = rd_active && ready;

    raster_counter #(
        .X_COUNT (LINE_LENGTH),
        .Y_COUNT (NUM_LINES)
    ) u_rd_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (frame_start_c),
        .en     (mem_rd),
        .x      (rd_x_unused),
        .y      (rd_y_unused),
        .last_c (rd_last_c)
    );

    raster_counter #(
        .X_COUNT (LINE_LENGTH),
        .Y_COUNT (NUM_LINES)
    ) u_out_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (frame_start_c),
        .en     (pix_en),
        .x      (ox),
        .y      (oy),
        .last_c (out_last_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            rd_active <= 1'b0;
            rd_pend   <= 1'b0;
            mem_addr  <= '0;
            pix_out   <= '0;
            pix_en    <= 1'b0;
            win_valid <= 1'b0;
            win_x     <= '0;
            win_y     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // Read data pipeline: strobe -> data return -> registered pixel.
            rd_pend <= mem_rd;
            pix_en  <= rd_pend;
            if (rd_pend) begin
                pix_out <= mem_rdata;
            end

            // Window flag tracks the line buffer's registered update of the newest pixel.
            win_valid <= pix_en && (ox >= XW'(WIN_W - 1)) && (oy >= YW'(WIN_H - 1));
            if (pix_en) begin
                win_x <= ox;
                win_y <= oy;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_READ;
                        busy      <= 1'b1;
                        rd_active <= 1'b1;
                        mem_addr  <= '0;
                    end
                end
                ST_READ: begin
                    if (mem_rd) begin
                        if (rd_last_c) begin
                            state     <= ST_DRAIN;
                            rd_active <= 1'b0;
                        end else begin
                            mem_addr <= mem_addr + ADDR_WIDTH'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    // done lands on the final window slot; busy drops one cycle later.
                    if (done) begin
                        done     <= 1'b0;
                        busy     <= 1'b0;
                        mem_addr <= '0;
                        state    <= ST_IDLE;
                    end else if (pix_en && out_last_c) begin
                        done <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    rd_active <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule
